fpu_iter_share_sched: RTL and testbench

//  Shares one fixed-latency iterative FPU unit (FDIV/FSQRT) between the upper and lower issue lanes.

---
 rtl/fpu_iter_share_if.sv | 42 ++++
 rtl/fpu_iter_share_sched.sv | 190 +++++++++++++++++++
 tb/tb_fpu_iter_share_sched.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_iter_share_if.sv
// Lane request, shared-unit and writeback signals of the FDIV/FSQRT sharing scheduler.
// The master side is exec plus the shared unit; the slave side is the scheduler itself.
interface fpu_iter_share_if;
    logic        u_req;
    logic        u_op;
    logic [31:0] u_srca;
    logic [31:0] u_srcb;
    logic [4:0]  u_rt;
    logic        l_req;
    logic        l_op;
    logic [31:0] l_srca;
    logic [31:0] l_srcb;
    logic [4:0]  l_rt;
    logic        stall;
    logic        unit_start;
    logic        unit_op;
    logic [31:0] unit_srca;
    logic [31:0] unit_srcb;
    logic [31:0] unit_result;
    logic        u_wb_valid;
    logic [4:0]  u_wb_rt;
    logic [31:0] u_wb_data;
    logic        l_wb_valid;
    logic [4:0]  l_wb_rt;
    logic [31:0] l_wb_data;

    modport master (
        output u_req, u_op, u_srca, u_srcb, u_rt,
        output l_req, l_op, l_srca, l_srcb, l_rt,
        output unit_result,
        input  stall, unit_start, unit_op, unit_srca, unit_srcb,
        input  u_wb_valid, u_wb_rt, u_wb_data, l_wb_valid, l_wb_rt, l_wb_data
    );

    modport slave (
        input  u_req, u_op, u_srca, u_srcb, u_rt,
        input  l_req, l_op, l_srca, l_srcb, l_rt,
        input  unit_result,
        output stall, unit_start, unit_op, unit_srca, unit_srcb,
        output u_wb_valid, u_wb_rt, u_wb_data, l_wb_valid, l_wb_rt, l_wb_data
    );
endinterface

// File: rtl/fpu_iter_share_sched.sv
// Shares one fixed-latency iterative FDIV/FSQRT unit between the upper and lower issue lanes:
// one active op plus one pending slot, results returned on the originating lane.
module fpu_iter_share_sched #(
    parameter int LAT   = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    fpu_iter_share_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             act_lane_r;
    logic [4:0]       act_rt_r;
    logic             pend_valid_r, pend_lane_r, pend_op_r;
    logic [31:0]      pend_srca_r, pend_srcb_r;
    logic [4:0]       pend_rt_r;
    logic             unit_start_r, unit_op_r;
    logic [31:0]      unit_srca_r, unit_srcb_r;
    logic             u_wb_valid_r, l_wb_valid_r;
    logic [4:0]       u_wb_rt_r, l_wb_rt_r;
    logic [31:0]      u_wb_data_r, l_wb_data_r;

    logic [1:0]       free_s, n_s;
    logic             stall_s, accept_s, capture_s;
    logic             inc_lane_s, inc_op_s;
    logic [31:0]      inc_srca_s, inc_srcb_s;
    logic [4:0]       inc_rt_s;

    // Acceptance decision and selection of the oldest incoming request (upper before lower)
    always_comb begin
        free_s     = {1'b0, (state_r == ST_IDLE)} + {1'b0, ~pend_valid_r};
        n_s        = {1'b0, bus.u_req} + {1'b0, bus.l_req};
        stall_s    = rst | (n_s > free_s);
        accept_s   = ~stall_s & (n_s != 2'd0);
        capture_s  = (state_r == ST_RUN) & ~unit_start_r & (cnt_r == CNT_W'(1));
        inc_lane_s = ~bus.u_req;
        inc_op_s   = bus.u_req ? bus.u_op   : bus.l_op;
        inc_srca_s = bus.u_req ? bus.u_srca : bus.l_srca;
        inc_srcb_s = bus.u_req ? bus.u_srcb : bus.l_srcb;
        inc_rt_s   = bus.u_req ? bus.u_rt   : bus.l_rt;
    end

    // Next-state logic of the sequencing FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_RUN;
                else          state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (capture_s) state_nxt_s = ST_WB;
                else           state_nxt_s = ST_RUN;
            end
            ST_WB: begin
                if (pend_valid_r | accept_s) state_nxt_s = ST_RUN;
                else                         state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Slots, latency counter, unit operand registers and writeback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= '0;
            act_lane_r   <= 1'b0;
            act_rt_r     <= 5'd0;
            pend_valid_r <= 1'b0;
            pend_lane_r  <= 1'b0;
            pend_op_r    <= 1'b0;
            pend_srca_r  <= 32'd0;
            pend_srcb_r  <= 32'd0;
            pend_rt_r    <= 5'd0;
            unit_start_r <= 1'b0;
            unit_op_r    <= 1'b0;
            unit_srca_r  <= 32'd0;
            unit_srcb_r  <= 32'd0;
            u_wb_valid_r <= 1'b0;
            l_wb_valid_r <= 1'b0;
            u_wb_rt_r    <= 5'd0;
            l_wb_rt_r    <= 5'd0;
            u_wb_data_r  <= 32'd0;
            l_wb_data_r  <= 32'd0;
        end else begin
            unit_start_r <= 1'b0;
            u_wb_valid_r <= 1'b0;
            l_wb_valid_r <= 1'b0;
            if (unit_start_r)         cnt_r <= LAT_C;
            else if (cnt_r != '0)     cnt_r <= cnt_r - CNT_W'(1);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        unit_start_r <= 1'b1;
                        unit_op_r    <= inc_op_s;
                        unit_srca_r  <= inc_srca_s;
                        unit_srcb_r  <= inc_srcb_s;
                        act_lane_r   <= inc_lane_s;
                        act_rt_r     <= inc_rt_s;
                        if (n_s == 2'd2) begin
                            pend_valid_r <= 1'b1;
                            pend_lane_r  <= 1'b1;
                            pend_op_r    <= bus.l_op;
                            pend_srca_r  <= bus.l_srca;
                            pend_srcb_r  <= bus.l_srcb;
                            pend_rt_r    <= bus.l_rt;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        pend_valid_r <= 1'b1;
                        pend_lane_r  <= inc_lane_s;
                        pend_op_r    <= inc_op_s;
                        pend_srca_r  <= inc_srca_s;
                        pend_srcb_r  <= inc_srcb_s;
                        pend_rt_r    <= inc_rt_s;
                    end
                    // The pending op's operands must already be on the unit in the WB cycle
                    if (capture_s) begin
                        if (act_lane_r) begin
                            l_wb_valid_r <= 1'b1;
                            l_wb_rt_r    <= act_rt_r;
                            l_wb_data_r  <= bus.unit_result;
                        end else begin
                            u_wb_valid_r <= 1'b1;
                            u_wb_rt_r    <= act_rt_r;
                            u_wb_data_r  <= bus.unit_result;
                        end
                        if (pend_valid_r) begin
                            unit_start_r <= 1'b1;
                            unit_op_r    <= pend_op_r;
                            unit_srca_r  <= pend_srca_r;
                            unit_srcb_r  <= pend_srcb_r;
                        end else if (accept_s) begin
                            unit_start_r <= 1'b1;
                            unit_op_r    <= inc_op_s;
                            unit_srca_r  <= inc_srca_s;
                            unit_srcb_r  <= inc_srcb_s;
                        end
                    end
                end
                ST_WB: begin
                    if (pend_valid_r) begin
                        pend_valid_r <= 1'b0;
                        act_lane_r   <= pend_lane_r;
                        act_rt_r     <= pend_rt_r;
                    end else if (accept_s) begin
                        unit_start_r <= 1'b1;
                        unit_op_r    <= inc_op_s;
                        unit_srca_r  <= inc_srca_s;
                        unit_srcb_r  <= inc_srcb_s;
                        act_lane_r   <= inc_lane_s;
                        act_rt_r     <= inc_rt_s;
                    end
                end
                default: begin
                    pend_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall      = stall_s;
    assign bus.unit_start = unit_start_r;
    assign bus.unit_op    = unit_op_r;
    assign bus.unit_srca  = unit_srca_r;
    assign bus.unit_srcb  = unit_srcb_r;
    assign bus.u_wb_valid = u_wb_valid_r;
    assign bus.u_wb_rt    = u_wb_rt_r;
    assign bus.u_wb_data  = u_wb_data_r;
    assign bus.l_wb_valid = l_wb_valid_r;
    assign bus.l_wb_rt    = l_wb_rt_r;
    assign bus.l_wb_data  = l_wb_data_r;
endmodule

// File: tb/tb_fpu_iter_share_sched.sv
// Scoreboard bench for fpu_iter_share_sched with LAT=4: directed scenarios push expected
// unit starts and writebacks, a negedge monitor pops and compares them.
module tb_fpu_iter_share_sched;
    localparam int LAT = 4;
    localparam logic [31:0] RBASE = 32'h5A00_0000;

    typedef struct {
        int          cyc;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
    } start_t;

    typedef struct {
        int          cyc;
        logic        lane;
        logic [4:0]  rt;
        logic [31:0] data;
    } wb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   t0  = 0;
    int   ncmp = 0;
    int   nfail = 0;
    start_t st_q[$];
    wb_t    wb_q[$];

    fpu_iter_share_if bus ();

    fpu_iter_share_sched #(.LAT(LAT), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Result tag depends on the cycle, so a capture in the wrong cycle shows up in the data
    assign bus.unit_result = RBASE ^ 32'(cyc);

    task automatic at(input int k);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < t0 + k);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, exp, cyc - t0);
        end
    endtask

    task automatic exp_start(input int k, input logic op, input logic [31:0] a, input logic [31:0] b);
        start_t s;
        s.cyc = t0 + k; s.op = op; s.a = a; s.b = b;
        st_q.push_back(s);
    endtask

    task automatic exp_wb(input int k, input logic lane, input logic [4:0] rt);
        wb_t w;
        w.cyc = t0 + k; w.lane = lane; w.rt = rt; w.data = RBASE ^ 32'(t0 + k - 1);
        wb_q.push_back(w);
    endtask

    task automatic drive_u(input logic req, input logic op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rt);
        bus.u_req = req; bus.u_op = op; bus.u_srca = a; bus.u_srcb = b; bus.u_rt = rt;
    endtask

    task automatic drive_l(input logic req, input logic op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rt);
        bus.l_req = req; bus.l_op = op; bus.l_srca = a; bus.l_srcb = b; bus.l_rt = rt;
    endtask

    task automatic new_scenario();
        @(posedge clk);
        #1;
        t0 = cyc + 1;
    endtask

    task automatic drained(input string name);
        chk({name, "_starts_left"}, 32'(st_q.size()), 32'd0);
        chk({name, "_wbs_left"}, 32'(wb_q.size()), 32'd0);
        st_q.delete();
        wb_q.delete();
    endtask

    // Monitor: every unit start and writeback pulse is matched against the scoreboard
    always @(negedge clk) begin
        start_t s;
        wb_t    w;
        if (bus.unit_start === 1'b1) begin
            ncmp++;
            if (st_q.size() == 0) begin
                nfail++;
                $display("FAIL start_unexpected: got start at cycle %0d, want none", cyc - t0);
            end else begin
                s = st_q.pop_front();
                if (s.cyc != cyc || s.op !== bus.unit_op || s.a !== bus.unit_srca || s.b !== bus.unit_srcb) begin
                    nfail++;
                    $display("FAIL start: got cyc=%0d op=%0b a=%h b=%h, want cyc=%0d op=%0b a=%h b=%h",
                             cyc - t0, bus.unit_op, bus.unit_srca, bus.unit_srcb, s.cyc - t0, s.op, s.a, s.b);
                end
            end
        end
        if (bus.u_wb_valid === 1'b1 && bus.l_wb_valid === 1'b1) begin
            ncmp++;
            nfail++;
            $display("FAIL wb_both_lanes: got both wb_valid at cycle %0d, want at most one", cyc - t0);
        end else if (bus.u_wb_valid === 1'b1 || bus.l_wb_valid === 1'b1) begin
            ncmp++;
            if (wb_q.size() == 0) begin
                nfail++;
                $display("FAIL wb_unexpected: got wb lane=%0b at cycle %0d, want none", bus.l_wb_valid, cyc - t0);
            end else begin
                w = wb_q.pop_front();
                if (w.cyc != cyc || w.lane !== bus.l_wb_valid ||
                    w.rt !== (bus.l_wb_valid ? bus.l_wb_rt : bus.u_wb_rt) ||
                    w.data !== (bus.l_wb_valid ? bus.l_wb_data : bus.u_wb_data)) begin
                    nfail++;
                    $display("FAIL wb: got cyc=%0d lane=%0b rt=%0d data=%h, want cyc=%0d lane=%0b rt=%0d data=%h",
                             cyc - t0, bus.l_wb_valid, bus.l_wb_valid ? bus.l_wb_rt : bus.u_wb_rt,
                             bus.l_wb_valid ? bus.l_wb_data : bus.u_wb_data, w.cyc - t0, w.lane, w.rt, w.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_u(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        drive_l(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(bus.stall), 32'd1);
        chk("rst_unit_start", 32'(bus.unit_start), 32'd0);
        chk("rst_unit_srca", bus.unit_srca, 32'd0);
        chk("rst_wb_valid", {30'd0, bus.u_wb_valid, bus.l_wb_valid}, 32'd0);
        chk("rst_wb_data", bus.u_wb_data | bus.l_wb_data, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_stall", 32'(bus.stall), 32'd0);

        // 1: single upper fdiv
        new_scenario();
        at(0);
        drive_u(1'b1, 1'b0, 32'h4040_0000, 32'h3F80_0000, 5'd3);
        exp_start(1, 1'b0, 32'h4040_0000, 32'h3F80_0000);
        exp_wb(1 + LAT + 1, 1'b0, 5'd3);
        #1 chk("s1_stall", 32'(bus.stall), 32'd0);
        at(1);
        drive_u(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        at(9);
        drained("s1");

        // 2 + 3: both lanes together, then a lower request that must wait for a free slot
        new_scenario();
        at(0);
        drive_u(1'b1, 1'b0, 32'h0000_0011, 32'h0000_0012, 5'd1);
        drive_l(1'b1, 1'b1, 32'h0000_0021, 32'h0000_0022, 5'd2);
        exp_start(1, 1'b0, 32'h0000_0011, 32'h0000_0012);
        exp_wb(6, 1'b0, 5'd1);
        exp_start(6, 1'b1, 32'h0000_0021, 32'h0000_0022);
        exp_wb(11, 1'b1, 5'd2);
        exp_start(11, 1'b0, 32'h0000_0031, 32'h0000_0032);
        exp_wb(16, 1'b1, 5'd7);
        #1 chk("s2_stall", 32'(bus.stall), 32'd0);
        at(1);
        drive_u(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        drive_l(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        at(2);
        drive_l(1'b1, 1'b0, 32'h0000_0031, 32'h0000_0032, 5'd7);
        for (int k = 2; k <= 6; k++) begin
            if (k > 2) at(k);
            #1 chk($sformatf("s3_stall_c%0d", k), 32'(bus.stall), 32'd1);
        end
        at(7);
        #1 chk("s3_accept", 32'(bus.stall), 32'd0);
        at(8);
        drive_l(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        at(18);
        drained("s3");

        // 4: two requests while an op runs stall until the unit is idle
        new_scenario();
        at(0);
        drive_u(1'b1, 1'b0, 32'h0000_0041, 32'h0000_0042, 5'd4);
        exp_start(1, 1'b0, 32'h0000_0041, 32'h0000_0042);
        exp_wb(6, 1'b0, 5'd4);
        at(1);
        drive_u(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        at(2);
        drive_u(1'b1, 1'b0, 32'h0000_0051, 32'h0000_0052, 5'd5);
        drive_l(1'b1, 1'b1, 32'h0000_0061, 32'h0000_0062, 5'd6);
        for (int k = 2; k <= 6; k++) begin
            if (k > 2) at(k);
            #1 chk($sformatf("s4_stall_c%0d", k), 32'(bus.stall), 32'd1);
        end
        at(7);
        #1 chk("s4_accept", 32'(bus.stall), 32'd0);
        exp_start(8, 1'b0, 32'h0000_0051, 32'h0000_0052);
        exp_wb(13, 1'b0, 5'd5);
        exp_start(13, 1'b1, 32'h0000_0061, 32'h0000_0062);
        exp_wb(18, 1'b1, 5'd6);
        at(8);
        drive_u(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        drive_l(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        at(20);
        drained("s4");

        // 5: reset mid-operation drops both the active and the pending op
        new_scenario();
        at(0);
        drive_u(1'b1, 1'b0, 32'h0000_0071, 32'h0000_0072, 5'd1);
        drive_l(1'b1, 1'b0, 32'h0000_0081, 32'h0000_0082, 5'd2);
        exp_start(1, 1'b0, 32'h0000_0071, 32'h0000_0072);
        at(1);
        drive_u(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        drive_l(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        at(3);
        rst = 1'b1;
        #1 chk("s5_rst_stall", 32'(bus.stall), 32'd1);
        at(4);
        rst = 1'b0;
        at(5);
        drive_u(1'b1, 1'b0, 32'h0000_0091, 32'h0000_0092, 5'd9);
        exp_start(6, 1'b0, 32'h0000_0091, 32'h0000_0092);
        exp_wb(11, 1'b0, 5'd9);
        #1 chk("s5_stall", 32'(bus.stall), 32'd0);
        at(6);
        drive_u(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        at(14);
        drained("s5");

        // 6: back-to-back fsqrt, second issued in the WB cycle of the first
        new_scenario();
        at(0);
        drive_u(1'b1, 1'b1, 32'h4080_0000, 32'h0000_0000, 5'd10);
        exp_start(1, 1'b1, 32'h4080_0000, 32'h0000_0000);
        exp_wb(6, 1'b0, 5'd10);
        at(1);
        drive_u(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        for (int k = 2; k <= 5; k++) begin
            at(k);
            chk($sformatf("s6_srca_c%0d", k), bus.unit_srca, 32'h4080_0000);
        end
        at(6);
        drive_u(1'b1, 1'b1, 32'h4110_0000, 32'h0000_0000, 5'd11);
        exp_start(7, 1'b1, 32'h4110_0000, 32'h0000_0000);
        exp_wb(12, 1'b0, 5'd11);
        #1 chk("s6_stall", 32'(bus.stall), 32'd0);
        at(7);
        drive_u(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        at(14);
        drained("s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
